// File: rtl/ir_prefetch_queue.sv
// Instruction register backed by an in-order prefetch queue; the head byte is the IR.
// Latency: a byte pushed into an empty queue appears on 'out' one cycle after the push.
// Backpressure: none; pushes into a full queue are dropped (ovf), pops from empty are ignored (udf).
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   we, bus             push 'bus' at the tail
//   pop                 consume the head entry
//   flush               discard all entries; a same-cycle push survives as the only entry
//   clr_err             clear the sticky ovf/udf flags
//   out, valid, full    head entry (0 when empty), non-empty, count == DEPTH
//   count               entries held, 0..DEPTH
//   ovf, udf            sticky overflow / underflow flags
//   peek1, peek2, pvalid  (only when IR_PEEK_EN is defined) entries behind the head
//
// Optional feature macro: IR_PEEK_EN
module ir_prefetch_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] bus,
    input  logic             pop,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count,
`ifdef IR_PEEK_EN
    output logic [WIDTH-1:0] peek1,
    output logic [WIDTH-1:0] peek2,
    output logic [1:0]       pvalid,
`endif
    output logic             ovf,
    output logic             udf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt, wr_nxt, waddr;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             wen, set_ovf, set_udf;
    logic             empty_q, full_q;

    assign empty_q = (cnt == '0);
    assign full_q  = (cnt == CW'(DEPTH));

    // Next-state decode, highest priority first. Pointers are AW bits wide and
    // DEPTH is a power of two, so the natural overflow of the adders is the wrap.
    always_comb begin
        rd_nxt  = rd_ptr;
        wr_nxt  = wr_ptr;
        cnt_nxt = cnt;
        wen     = 1'b0;
        waddr   = wr_ptr;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (flush) begin
            rd_nxt  = '0;
            wr_nxt  = '0;
            cnt_nxt = '0;
            if (we) begin
                // Branch-target byte is kept as the new head at index 0.
                wen     = 1'b1;
                waddr   = '0;
                wr_nxt  = AW'(1);
                cnt_nxt = CW'(1);
            end
        end else if (we && pop) begin
            wen    = 1'b1;
            wr_nxt = wr_ptr + AW'(1);
            if (!empty_q) begin
                rd_nxt = rd_ptr + AW'(1);
            end else begin
                // Empty: head and tail coincide, so the new byte becomes the head.
                set_udf = 1'b1;
                cnt_nxt = CW'(1);
            end
        end else if (we) begin
            if (!full_q) begin
                wen     = 1'b1;
                wr_nxt  = wr_ptr + AW'(1);
                cnt_nxt = cnt + CW'(1);
            end else begin
                set_ovf = 1'b1;
            end
        end else if (pop) begin
            if (!empty_q) begin
                rd_nxt  = rd_ptr + AW'(1);
                cnt_nxt = cnt - CW'(1);
            end else begin
                set_udf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            cnt    <= cnt_nxt;
            // A new error in the same cycle as clr_err keeps the flag set.
            ovf    <= set_ovf | (ovf & ~clr_err);
            udf    <= set_udf | (udf & ~clr_err);
            if (wen) begin
                mem[waddr] <= bus;
            end
        end
    end

    // Storage is never cleared on pop/flush, so stale bytes are masked by count.
    assign out   = empty_q ? '0 : mem[rd_ptr];
    assign valid = !empty_q;
    assign full  = full_q;
    assign count = cnt;

`ifdef IR_PEEK_EN
    assign peek1  = (cnt >= CW'(2)) ? mem[rd_ptr + AW'(1)] : '0;
    assign pvalid = {cnt >= CW'(3), cnt >= CW'(2)};
    generate
        if (DEPTH > 2) begin : g_peek2
            assign peek2 = (cnt >= CW'(3)) ? mem[rd_ptr + AW'(2)] : '0;
        end else begin : g_no_peek2
            assign peek2 = '0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ir_prefetch_queue.sv
module tb_ir_prefetch_queue;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [W-1:0]  bus = '0;
    logic [W-1:0]  out;
    logic          valid, full, ovf, udf;
    logic [CW-1:0] count;
`ifdef IR_PEEK_EN
    logic [W-1:0]  peek1, peek2;
    logic [1:0]    pvalid;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents as a plain byte queue plus flag bits.
    logic [W-1:0] mq [$];
    logic         movf = 1'b0, mudf = 1'b0;

    ir_prefetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .bus(bus), .pop(pop), .flush(flush),
        .clr_err(clr_err), .out(out), .valid(valid), .full(full), .count(count),
`ifdef IR_PEEK_EN
        .peek1(peek1), .peek2(peek2), .pvalid(pvalid),
`endif
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model applies the same operation from the
    // behavioural rules, then outputs are observable 1 ns after the edge.
    task automatic cyc(input logic w, input logic [W-1:0] b, input logic p,
                       input logic f, input logic c);
        bit ov_ev, ud_ev;
        we = w; bus = b; pop = p; flush = f; clr_err = c;
        ud_ev = p && !f && (mq.size() == 0);
        ov_ev = w && !p && !f && (mq.size() == D);
        if (f) mq.delete();
        else if (p && mq.size() > 0) void'(mq.pop_front());
        if (w && !ov_ev) mq.push_back(b);
        movf = ov_ev | (movf & ~c);
        mudf = ud_ev | (mudf & ~c);
        @(posedge clk);
        #1;
        we = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; bus = '0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (out !== 8'h00 || count !== 3'd0 || valid !== 1'b0 || full !== 1'b0)
            begin errors++; $display("FAIL reset_init out=%h count=%0d valid=%b full=%b want 00/0/0/0", out, count, valid, full); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'h22, 0, 0, 0); cyc(1, 8'h33, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0); cyc(0, 8'h00, 1, 0, 0); cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);     // underflow so udf is set before reset
        cyc(1, 8'h44, 0, 0, 0); cyc(1, 8'h55, 0, 0, 0); cyc(1, 8'h66, 0, 0, 0);
        checks++; if (count !== 3'd3 || out !== 8'h44 || udf !== 1'b1)
            begin errors++; $display("FAIL pre_reset count=%0d out=%h udf=%b want 3/44/1", count, out, udf); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out !== 8'h00 || count !== 3'd0 || valid !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0)
            begin errors++; $display("FAIL async_reset out=%h count=%0d valid=%b ovf=%b udf=%b want 00/0/0/0/0", out, count, valid, ovf, udf); end
        mq.delete(); movf = 1'b0; mudf = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop;
        cyc(1, 8'h3E, 0, 0, 0);
        checks++; if (out !== 8'h3E || count !== 3'd1 || valid !== 1'b1)
            begin errors++; $display("FAIL push1 out=%h count=%0d valid=%b want 3e/1/1", out, count, valid); end
        cyc(1, 8'h42, 0, 0, 0);
        checks++; if (out !== 8'h3E || count !== 3'd2)
            begin errors++; $display("FAIL push2 out=%h count=%0d want 3e/2", out, count); end
        cyc(0, 8'h00, 1, 0, 0);
        checks++; if (out !== 8'h42 || count !== 3'd1)
            begin errors++; $display("FAIL pop1 out=%h count=%0d want 42/1", out, count); end
        cyc(0, 8'h00, 1, 0, 0);
        checks++; if (out !== 8'h00 || count !== 3'd0 || valid !== 1'b0 || udf !== 1'b0)
            begin errors++; $display("FAIL pop_to_empty out=%h count=%0d valid=%b udf=%b want 00/0/0/0", out, count, valid, udf); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 5; i++) begin
            cyc(1, W'(i), 0, 0, 0);
            if (i == 4) begin
                checks++; if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b0)
                    begin errors++; $display("FAIL fill full=%b count=%0d ovf=%b want 1/4/0", full, count, ovf); end
            end
        end
        checks++; if (ovf !== 1'b1 || out !== 8'h01 || count !== 3'd4)
            begin errors++; $display("FAIL overflow ovf=%b out=%h count=%0d want 1/01/4", ovf, out, count); end
        cyc(0, 8'h00, 0, 0, 1);
        checks++; if (ovf !== 1'b0 || count !== 3'd4)
            begin errors++; $display("FAIL clr_ovf ovf=%b count=%0d want 0/4", ovf, count); end
    endtask

    task automatic test_full_push_pop;
        cyc(1, 8'hAA, 1, 0, 0);
        checks++; if (count !== 3'd4 || out !== 8'h02 || ovf !== 1'b0 || full !== 1'b1)
            begin errors++; $display("FAIL full_pushpop count=%0d out=%h ovf=%b full=%b want 4/02/0/1", count, out, ovf, full); end
        cyc(0, 8'h00, 1, 0, 0); cyc(0, 8'h00, 1, 0, 0); cyc(0, 8'h00, 1, 0, 0);
        checks++; if (out !== 8'hAA || count !== 3'd1)
            begin errors++; $display("FAIL tail_aa out=%h count=%0d want aa/1", out, count); end
    endtask

    task automatic test_flush;
        cyc(1, 8'hB1, 0, 0, 0); cyc(1, 8'hB2, 0, 0, 0);
        cyc(1, 8'hC3, 0, 1, 0);
        checks++; if (count !== 3'd1 || out !== 8'hC3)
            begin errors++; $display("FAIL flush_we count=%0d out=%h want 1/c3", count, out); end
        cyc(0, 8'h00, 1, 1, 0);     // pop alongside flush is not an underflow
        checks++; if (count !== 3'd0 || out !== 8'h00 || udf !== 1'b0)
            begin errors++; $display("FAIL flush count=%0d out=%h udf=%b want 0/00/0", count, out, udf); end
    endtask

    task automatic test_underflow;
        cyc(0, 8'h00, 1, 0, 0);
        checks++; if (udf !== 1'b1 || count !== 3'd0)
            begin errors++; $display("FAIL underflow udf=%b count=%0d want 1/0", udf, count); end
        cyc(0, 8'h00, 1, 0, 1);     // new error beats clear
        checks++; if (udf !== 1'b1)
            begin errors++; $display("FAIL clr_vs_err udf=%b want 1", udf); end
        cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'h77, 1, 0, 0);     // push+pop on empty: push kept, udf set
        checks++; if (udf !== 1'b1 || count !== 3'd1 || out !== 8'h77)
            begin errors++; $display("FAIL empty_pushpop udf=%b count=%0d out=%h want 1/1/77", udf, count, out); end
        cyc(0, 8'h00, 1, 0, 1);
        cyc(1, 8'hCD, 0, 0, 0); cyc(1, 8'h34, 0, 0, 0); cyc(1, 8'h12, 0, 0, 0);
        checks++; if (out !== 8'hCD || count !== 3'd3 || udf !== 1'b0)
            begin errors++; $display("FAIL opcode out=%h count=%0d udf=%b want cd/3/0", out, count, udf); end
`ifdef IR_PEEK_EN
        checks++; if (peek1 !== 8'h34 || peek2 !== 8'h12 || pvalid !== 2'b11)
            begin errors++; $display("FAIL peek p1=%h p2=%h pv=%b want 34/12/11", peek1, peek2, pvalid); end
`endif
    endtask

    task automatic test_random;
        logic [W-1:0] exp_out;
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) < 55), W'($urandom), ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 8));
            exp_out = (mq.size() > 0) ? mq[0] : '0;
            checks++;
            if (out !== exp_out || count !== CW'(mq.size()) || valid !== (mq.size() > 0) ||
                full !== (mq.size() == D) || ovf !== movf || udf !== mudf) begin
                errors++;
                $display("FAIL random[%0d] out=%h cnt=%0d v=%b f=%b ovf=%b udf=%b want %h/%0d/%b/%b/%b/%b",
                         n, out, count, valid, full, ovf, udf, exp_out, mq.size(),
                         (mq.size() > 0), (mq.size() == D), movf, mudf);
            end
`ifdef IR_PEEK_EN
            checks++;
            if (peek1 !== ((mq.size() > 1) ? mq[1] : 8'h00) ||
                peek2 !== ((mq.size() > 2) ? mq[2] : 8'h00) ||
                pvalid !== {(mq.size() > 2), (mq.size() > 1)}) begin
                errors++;
                $display("FAIL random_peek[%0d] p1=%h p2=%h pv=%b size=%0d", n, peek1, peek2, pvalid, mq.size());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_underflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
